// File: rtl/controle_cofre_pkg.sv
// Shared definitions for the safe controller.
//   estado_t : controller FSM states
//   TIMER_W  : width of the lockout down-counter
//   ERROS_W  : width of the consecutive-failure counter
package cofre_pkg;

  localparam int TIMER_W = 26;
  localparam int ERROS_W = 2;

  typedef enum logic [2:0] {
    SEM_SENHA = 3'd0,
    AGUARDA   = 3'd1,
    AVALIA    = 3'd2,
    ABERTO    = 3'd3,
    BLOQUEADO = 3'd4
  } estado_t;

endpackage

// File: rtl/controle_cofre_if.sv
// User-side and comparator-side signals of the safe controller.
//   chaves           : slide-switch value (to controller)
//   btn_gravar       : store-password button, asynchronous (to controller)
//   btn_tentar       : try/close button, asynchronous (to controller)
//   igual            : comparator result for senha/tentativa (to controller)
//   senha            : stored password (from controller)
//   tentativa        : latched attempt (from controller)
//   tentativa_valida : one-cycle strobe while igual is evaluated (from controller)
//   aberto           : safe open (from controller)
//   bloqueado        : lockout active (from controller)
//   erros            : consecutive-failure count (from controller)
interface controle_cofre_if;

  logic [3:0]                  chaves;
  logic                        btn_gravar;
  logic                        btn_tentar;
  logic                        igual;
  logic [3:0]                  senha;
  logic [3:0]                  tentativa;
  logic                        tentativa_valida;
  logic                        aberto;
  logic                        bloqueado;
  logic [cofre_pkg::ERROS_W-1:0] erros;

  modport master (
    output chaves, btn_gravar, btn_tentar, igual,
    input  senha, tentativa, tentativa_valida, aberto, bloqueado, erros
  );

  modport slave (
    input  chaves, btn_gravar, btn_tentar, igual,
    output senha, tentativa, tentativa_valida, aberto, bloqueado, erros
  );

endinterface

// File: rtl/controle_cofre_sincroniza_botao.sv
// Button conditioner: 2-flop synchronizer followed by a rising-edge detector.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   btn   : raw asynchronous button (active high)
//   pulso : one-cycle pulse per press, valid between the 2nd and 3rd edge
//           after the button is first sampled high
module sincroniza_botao (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic pulso
);

  logic sync_p0;
  logic sync_p1;
  logic sync_p2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      sync_p2 <= 1'b0;
    end else begin
      // stage p0/p1: metastability filter; p2: previous value for edge detect
      sync_p0 <= btn;
      sync_p1 <= sync_p0;
      sync_p2 <= sync_p1;
    end
  end

  // Reset clears p2, so a button held through reset counts as a new press.
  assign pulso = sync_p1 & ~sync_p2;

endmodule

// File: rtl/controle_cofre.sv
// Digital safe controller: stores a 4-bit password, evaluates attempts
// through an external comparator and locks out after repeated failures.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : controle_cofre_if.slave (switches, buttons, comparator result,
//           password/attempt, status outputs)
module controle_cofre
  import cofre_pkg::*;
#(
  parameter int MAX_ERROS  = 3,
  parameter int T_BLOQUEIO = 50000000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  controle_cofre_if.slave        bus
);

  localparam logic [ERROS_W-1:0] ERROS_MAX  = ERROS_W'(MAX_ERROS);
  localparam logic [TIMER_W-1:0] TIMER_CARGA = TIMER_W'(T_BLOQUEIO - 1);

  estado_t              state;
  estado_t              state_next;
  logic [3:0]           senha_q;
  logic [3:0]           tentativa_q;
  logic [ERROS_W-1:0]   erros_q;
  logic [ERROS_W-1:0]   erros_inc;
  logic [TIMER_W-1:0]   timer_q;
  logic                 aberto_q;
  logic                 bloqueado_q;
  logic                 ev_gravar;
  logic                 ev_tentar;
  logic                 timer_zero;

  logic ld_senha;
  logic ld_tentativa;
  logic clr_erros;
  logic inc_erros;
  logic ld_timer;
  logic dec_timer;

  function automatic logic [ERROS_W-1:0] sat_inc(input logic [ERROS_W-1:0] e);
    if (e >= ERROS_MAX) return e;
    else                return e + ERROS_W'(1);
  endfunction

  sincroniza_botao u_sync_gravar (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (bus.btn_gravar),
    .pulso (ev_gravar)
  );

  sincroniza_botao u_sync_tentar (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (bus.btn_tentar),
    .pulso (ev_tentar)
  );

  assign erros_inc  = sat_inc(erros_q);
  assign timer_zero = (timer_q == '0);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= SEM_SENHA;
    else        state <= state_next;
  end

  // Next-state logic; edges not listed for a state are simply dropped,
  // which covers both the AVALIA discard and the BLOQUEADO ignore.
  always_comb begin
    state_next = state;
    case (state)
      SEM_SENHA: if (ev_gravar) state_next = AGUARDA;
      AGUARDA:   if (ev_tentar) state_next = AVALIA;
      AVALIA: begin
        if (bus.igual)                   state_next = ABERTO;
        else if (erros_inc == ERROS_MAX) state_next = BLOQUEADO;
        else                             state_next = AGUARDA;
      end
      ABERTO:    if (ev_gravar || ev_tentar) state_next = AGUARDA;
      BLOQUEADO: if (timer_zero) state_next = AGUARDA;
      default:   state_next = SEM_SENHA;
    endcase
  end

  // Output / action decode
  always_comb begin
    ld_senha         = 1'b0;
    ld_tentativa     = 1'b0;
    clr_erros        = 1'b0;
    inc_erros        = 1'b0;
    ld_timer         = 1'b0;
    dec_timer        = 1'b0;
    bus.tentativa_valida = 1'b0;
    case (state)
      SEM_SENHA: ld_senha = ev_gravar;
      AGUARDA:   ld_tentativa = ev_tentar;
      AVALIA: begin
        bus.tentativa_valida = 1'b1;
        clr_erros = bus.igual;
        inc_erros = ~bus.igual;
        ld_timer  = ~bus.igual && (erros_inc == ERROS_MAX);
      end
      ABERTO: begin
        // gravar takes priority; tentar alone only closes the safe
        ld_senha  = ev_gravar;
        clr_erros = ev_gravar;
      end
      BLOQUEADO: begin
        dec_timer = ~timer_zero;
        clr_erros = timer_zero;
      end
      default: ;
    endcase
  end

  // Datapath and registered status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      senha_q     <= '0;
      tentativa_q <= '0;
      erros_q     <= '0;
      timer_q     <= '0;
      aberto_q    <= 1'b0;
      bloqueado_q <= 1'b0;
    end else begin
      if (ld_senha)     senha_q     <= bus.chaves;
      if (ld_tentativa) tentativa_q <= bus.chaves;
      if (clr_erros)      erros_q <= '0;
      else if (inc_erros) erros_q <= erros_inc;
      if (ld_timer)       timer_q <= TIMER_CARGA;
      else if (dec_timer) timer_q <= timer_q - TIMER_W'(1);
      // Status follows the state being entered so it aligns with the state
      // register; bloqueado then spans exactly T_BLOQUEIO cycles.
      aberto_q    <= (state_next == ABERTO);
      bloqueado_q <= (state_next == BLOQUEADO);
    end
  end

  assign bus.senha     = senha_q;
  assign bus.tentativa = tentativa_q;
  assign bus.erros     = erros_q;
  assign bus.aberto    = aberto_q;
  assign bus.bloqueado = bloqueado_q;

endmodule
